// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues sequential AXI-lite reads under a buffer credit,
// queues returned instructions in order and hands them to decode; redirects flush and drop stale responses.
module ifu_prefetch #(
  parameter int unsigned    PC_W     = 32,
  parameter int unsigned    INST_W   = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter int unsigned    MAX_OUT  = 2,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h8000_0000)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_valid_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              f_valid_o,
  input  logic              D_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              fault_o,
  output logic              mst_ar_valid_o,
  output logic [PC_W-1:0]   mst_ar_addr_o,
  input  logic              mst_ar_ready_i,
  input  logic              mst_r_valid_i,
  input  logic [INST_W-1:0] mst_r_data_i,
  input  logic [1:0]        mst_r_resp_i,
  output logic              mst_r_ready_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [PC_W-1:0]   buf_pc    [DEPTH];
  logic [INST_W-1:0] buf_inst  [DEPTH];
  logic              buf_fault [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop_cnt;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  resp_pc;
  logic             halted;
  logic             ar_valid;
  logic [PC_W-1:0]  ar_addr;
  logic             r_ready;

  logic r_hs;
  logic enq;
  logic deq;
  logic launch;
  logic ar_hs;
  logic r_fault;

  // Handshakes and the launch credit check; buffer space is reserved at launch time.
  always_comb begin
    r_hs    = mst_r_valid_i & r_ready;
    enq     = r_hs & (drop_cnt == '0);
    deq     = (count != '0) & D_ready_i;
    ar_hs   = ar_valid & mst_ar_ready_i;
    r_fault = (mst_r_resp_i != 2'b00);
    launch  = !ar_valid
            && (inflight < CNT_W'(MAX_OUT))
            && ((SUM_W'(inflight) + SUM_W'(count)) < SUM_W'(DEPTH))
            && !halted
            && !redirect_valid_i;
  end

  // Control state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      halted   <= 1'b0;
      ar_valid <= 1'b0;
      ar_addr  <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_ready  <= 1'b1;
      inflight <= inflight + CNT_W'(launch) - CNT_W'(r_hs);

      // The AR channel holds its request until accepted, even across a redirect.
      if (ar_hs) begin
        ar_valid <= 1'b0;
      end
      if (launch) begin
        ar_valid <= 1'b1;
        ar_addr  <= fetch_pc;
        fetch_pc <= fetch_pc + PC_W'(4);
      end

      if (redirect_valid_i) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        drop_cnt <= inflight - CNT_W'(r_hs);
        fetch_pc <= redirect_pc_i;
        resp_pc  <= redirect_pc_i;
        halted   <= 1'b0;
      end else begin
        if (enq) begin
          tail    <= tail + PTR_W'(1);
          resp_pc <= resp_pc + PC_W'(4);
          if (r_fault) begin
            halted <= 1'b1;
          end
        end else if (r_hs) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
        if (deq) begin
          head <= head + PTR_W'(1);
        end
        count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  // Buffer storage carries no reset; the head is gated by count.
  always_ff @(posedge clk_i) begin
    if (!rst_i && enq && !redirect_valid_i) begin
      buf_pc[tail]    <= resp_pc;
      buf_inst[tail]  <= mst_r_data_i;
      buf_fault[tail] <= r_fault;
    end
  end

  assign f_valid_o      = (count != '0);
  assign pc_o           = f_valid_o ? buf_pc[head]    : '0;
  assign inst_o         = f_valid_o ? buf_inst[head]  : '0;
  assign fault_o        = f_valid_o ? buf_fault[head] : 1'b0;
  assign mst_ar_valid_o = ar_valid;
  assign mst_ar_addr_o  = ar_addr;
  assign mst_r_ready_o  = r_ready;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: in-order AXI-lite slave with configurable latency,
// logs of AR addresses and decoded entries, checked against hand-computed values.
module tb_ifu_prefetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        f_valid_o;
  logic        D_ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        fault_o;
  logic        mst_ar_valid_o;
  logic [31:0] mst_ar_addr_o;
  logic        mst_ar_ready_i;
  logic        mst_r_valid_i;
  logic [31:0] mst_r_data_i;
  logic [1:0]  mst_r_resp_i;
  logic        mst_r_ready_o;

  ifu_prefetch dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .f_valid_o        (f_valid_o),
    .D_ready_i        (D_ready_i),
    .pc_o             (pc_o),
    .inst_o           (inst_o),
    .fault_o          (fault_o),
    .mst_ar_valid_o   (mst_ar_valid_o),
    .mst_ar_addr_o    (mst_ar_addr_o),
    .mst_ar_ready_i   (mst_ar_ready_i),
    .mst_r_valid_i    (mst_r_valid_i),
    .mst_r_data_i     (mst_r_data_i),
    .mst_r_resp_i     (mst_r_resp_i),
    .mst_r_ready_o    (mst_r_ready_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] ar_log [$];
  logic [31:0] dec_pc [$];
  logic [31:0] dec_inst [$];
  logic        dec_fault [$];
  logic [31:0] rq_addr [$];
  int          rq_due [$];
  int          cyc = 0;
  int          r_lat = 1;
  logic [31:0] fault_addr = 32'hFFFF_FFFF;
  int          n_ar = 0;
  int          n_r = 0;
  int          max_out = 0;
  int          first_r_ar = -1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ar_at(input int i);
    return (i < ar_log.size()) ? ar_log[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] dpc_at(input int i);
    return (i < dec_pc.size()) ? dec_pc[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] dinst_at(input int i);
    return (i < dec_inst.size()) ? dec_inst[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic dfault_at(input int i);
    return (i < dec_fault.size()) ? dec_fault[i] : 1'bx;
  endfunction

  // In-order slave: samples handshakes at negedge, updates after the edge. Data = addr + 0x1000_0000.
  initial begin
    logic        rst_s;
    logic        ar_hs_s;
    logic        r_hs_s;
    logic [31:0] ar_a_s;
    int          outst;
    mst_r_valid_i = 1'b0;
    mst_r_data_i  = '0;
    mst_r_resp_i  = 2'b00;
    forever begin
      @(negedge clk_i);
      rst_s   = rst_i;
      ar_hs_s = mst_ar_valid_o && mst_ar_ready_i;
      ar_a_s  = mst_ar_addr_o;
      r_hs_s  = mst_r_valid_i && mst_r_ready_o;
      if (!rst_s) begin
        if (f_valid_o && D_ready_i) begin
          dec_pc.push_back(pc_o);
          dec_inst.push_back(inst_o);
          dec_fault.push_back(fault_o);
        end
        outst = n_ar + (mst_ar_valid_o ? 1 : 0) - n_r;
        if (outst > max_out) max_out = outst;
        if (r_hs_s && n_r == 0 && first_r_ar < 0) first_r_ar = ar_log.size();
      end
      @(posedge clk_i);
      #1;
      cyc++;
      if (rst_s) begin
        rq_addr.delete(); rq_due.delete(); ar_log.delete();
        dec_pc.delete(); dec_inst.delete(); dec_fault.delete();
        n_ar = 0; n_r = 0; max_out = 0; first_r_ar = -1;
      end else begin
        if (ar_hs_s) begin
          rq_addr.push_back(ar_a_s);
          rq_due.push_back(cyc + r_lat - 1);
          ar_log.push_back(ar_a_s);
          n_ar++;
        end
        if (r_hs_s) begin
          void'(rq_addr.pop_front());
          void'(rq_due.pop_front());
          n_r++;
        end
      end
      if (rq_addr.size() > 0 && rq_due[0] <= cyc) begin
        mst_r_valid_i = 1'b1;
        mst_r_data_i  = rq_addr[0] + 32'h1000_0000;
        mst_r_resp_i  = (rq_addr[0] == fault_addr) ? 2'b10 : 2'b00;
      end else begin
        mst_r_valid_i = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset(input int lat, input logic ar_rdy, input logic d_rdy);
    rst_i            = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    mst_ar_ready_i   = ar_rdy;
    D_ready_i        = d_rdy;
    r_lat            = lat;
    fault_addr       = 32'hFFFF_FFFF;
    repeat (3) step();
    rst_i = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = pc;
    ar_log.delete(); dec_pc.delete(); dec_inst.delete(); dec_fault.delete();
    step();
    redirect_valid_i = 1'b0;
  endtask

  initial begin
    bit ok;
    int snap;

    // Reset state and sequential fetch with 1-cycle slave.
    do_reset(1, 1'b1, 1'b1);
    @(negedge clk_i);
    check_eq("rst_f_valid", f_valid_o, 0);
    check_eq("rst_ar_valid", mst_ar_valid_o, 0);
    check_eq("rst_fault", fault_o, 0);
    check_eq("rst_pc", pc_o, 0);
    check_eq("rst_inst", inst_o, 0);
    repeat (20) step();
    check_eq("t1_r_ready", mst_r_ready_o, 1);
    check_eq("t1_ar0", ar_at(0), 32'h8000_0000);
    check_eq("t1_ar1", ar_at(1), 32'h8000_0004);
    check_eq("t1_ar2", ar_at(2), 32'h8000_0008);
    check_eq("t1_d0_pc", dpc_at(0), 32'h8000_0000);
    check_eq("t1_d0_inst", dinst_at(0), 32'h9000_0000);
    check_eq("t1_d1_pc", dpc_at(1), 32'h8000_0004);
    check_eq("t1_d1_inst", dinst_at(1), 32'h9000_0004);
    check_eq("t1_d2_pc", dpc_at(2), 32'h8000_0008);
    check_eq("t1_d2_inst", dinst_at(2), 32'h9000_0008);

    // Decode stalled: buffer fills to DEPTH, then one pop frees one slot.
    do_reset(1, 1'b1, 1'b0);
    repeat (30) step();
    @(negedge clk_i);
    check_eq("t2_ar_cnt_full", ar_log.size(), 4);
    check_eq("t2_f_valid", f_valid_o, 1);
    check_eq("t2_ar_idle", mst_ar_valid_o, 0);
    check_eq("t2_head_pc", pc_o, 32'h8000_0000);
    step();
    D_ready_i = 1'b1;
    step();
    D_ready_i = 1'b0;
    repeat (20) step();
    check_eq("t2_pop_cnt", dec_pc.size(), 1);
    check_eq("t2_pop_pc", dpc_at(0), 32'h8000_0000);
    check_eq("t2_ar_cnt", ar_log.size(), 5);
    check_eq("t2_ar4", ar_at(4), 32'h8000_0010);

    // Slow slave: in-flight bounded by MAX_OUT, two ARs before the first R.
    do_reset(5, 1'b1, 1'b1);
    repeat (40) step();
    check_eq("t3_max_out", max_out, 2);
    check_eq("t3_ar_before_r", first_r_ar >= 2, 1);
    check_eq("t3_ar0", ar_at(0), 32'h8000_0000);
    check_eq("t3_ar1", ar_at(1), 32'h8000_0004);
    check_eq("t3_d0_pc", dpc_at(0), 32'h8000_0000);

    // Redirect with two requests in flight: both responses dropped.
    do_reset(8, 1'b1, 1'b1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (ar_log.size() == 2 && !mst_ar_valid_o) begin ok = 1; break; end
    end
    check_eq("t4_two_inflight", ok, 1);
    check_eq("t4_no_resp_yet", n_r, 0);
    step();
    redirect_to(32'h8000_0100);
    repeat (40) step();
    check_eq("t4_ar_new", ar_at(0), 32'h8000_0100);
    check_eq("t4_d0_pc", dpc_at(0), 32'h8000_0100);
    check_eq("t4_d0_inst", dinst_at(0), 32'h9000_0100);

    // Error response halts fetch until a redirect.
    do_reset(1, 1'b1, 1'b1);
    fault_addr = 32'h8000_0008;
    repeat (30) step();
    check_eq("t5_d2_pc", dpc_at(2), 32'h8000_0008);
    check_eq("t5_d2_fault", dfault_at(2), 1);
    check_eq("t5_d1_fault", dfault_at(1), 0);
    check_eq("t5_ar_cnt", ar_log.size(), 4);
    snap = ar_log.size();
    repeat (20) step();
    check_eq("t5_halted", ar_log.size(), snap);
    fault_addr = 32'hFFFF_FFFF;
    redirect_to(32'h8000_0200);
    repeat (30) step();
    check_eq("t5_resume_ar", ar_at(0), 32'h8000_0200);
    check_eq("t5_resume_pc", dpc_at(0), 32'h8000_0200);
    check_eq("t5_resume_fault", dfault_at(0), 0);
    check_eq("t5_resume_more", ar_log.size() >= 3, 1);

    // Redirect while an AR waits for ready: address held, its response dropped.
    do_reset(1, 1'b0, 1'b1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (mst_ar_valid_o) begin ok = 1; break; end
    end
    check_eq("t6_ar_pending", ok, 1);
    step();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0300;
    step();
    redirect_valid_i = 1'b0;
    repeat (3) step();
    @(negedge clk_i);
    check_eq("t6_ar_held_valid", mst_ar_valid_o, 1);
    check_eq("t6_ar_held_addr", mst_ar_addr_o, 32'h8000_0000);
    step();
    mst_ar_ready_i = 1'b1;
    repeat (30) step();
    check_eq("t6_ar0", ar_at(0), 32'h8000_0000);
    check_eq("t6_ar1", ar_at(1), 32'h8000_0300);
    check_eq("t6_d0_pc", dpc_at(0), 32'h8000_0300);
    check_eq("t6_d0_inst", dinst_at(0), 32'h9000_0300);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Parametrised instruction fetch unit with an in-order fetch buffer and multiple outstanding AXI-lite read requests. It fetches sequentially from the current fetch PC, buffers instruction/PC pairs, and hands them to the decode stage through a valid/ready handshake. A redirect from the back end (branch, jalr, trap, mret) flushes the buffer and discards responses still in flight. Sits between the AXI-lite instruction bus and the decode stage. Replaces the single-request, single-entry fetch stage.

Parameters:
PC_W, 32, PC / AXI address width
INST_W, 32, instruction / AXI read data width
DEPTH, 4, fetch buffer entries; power of two, >= 2
MAX_OUT, 2, maximum in-flight AR requests; 1..DEPTH
RESET_PC, 32'h8000_0000, fetch PC after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
redirect_valid_i  in  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  in  PC_W  new fetch PC
f_valid_o  out  1  buffer head valid, to decode
D_ready_i  in  1  decode accepts head
pc_o  out  PC_W  PC of head entry
inst_o  out  INST_W  instruction of head entry
fault_o  out  1  head entry got non-OKAY response
mst_ar_valid_o  out  1  AXI AR valid
mst_ar_addr_o  out  PC_W  AXI AR address
mst_ar_ready_i  in  1  AXI AR ready
mst_r_valid_i  in  1  AXI R valid
mst_r_data_i  in  INST_W  AXI R data
mst_r_resp_i  in  2  AXI R response
mst_r_ready_o  out  1  AXI R ready

Behaviour:
- One clock domain, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: fetch_pc=RESET_PC; buffer empty; inflight=0; drop_cnt=0; halted=0. f_valid_o=0, mst_ar_valid_o=0, fault_o=0, pc_o/inst_o=0.
- mst_r_ready_o is tied to 1 after reset. Buffer space is reserved at AR launch, so R never back-pressures.
- inflight: number of launched requests not yet answered. A request counts from the cycle mst_ar_valid_o rises. It decrements on each R handshake.
- Launch condition, evaluated when mst_ar_valid_o=0:
  - inflight < MAX_OUT, and
  - inflight + count < DEPTH, and
  - halted=0, and
  - redirect_valid_i=0.
  - On launch: next cycle mst_ar_valid_o=1, mst_ar_addr_o=fetch_pc. fetch_pc advances by 4, modulo 2^PC_W.
- AR stability: once mst_ar_valid_o=1, it and mst_ar_addr_o hold until mst_ar_ready_i=1, even across redirect or halt. A new launch can occur in the cycle after the AR handshake. Registered AR gives a max issue rate of one request per 2 cycles.
- The bus returns responses in order. Each R handshake is handled as follows:
  - drop_cnt>0: discard the response, drop_cnt-1.
  - Otherwise: enqueue {pc, data, resp!=0} at the tail. The entry pc is tracked by a resp_pc register, set to the redirect/reset PC and advanced by 4 per enqueue.
- Fault: enqueuing an entry with resp!=0 sets halted=1, which stops new launches. Only redirect or reset clears halted.
- Dequeue: on f_valid_o & D_ready_i, the head pops. f_valid_o = (count!=0). Head fields are driven combinationally from the buffer.
- Simultaneous enqueue and dequeue in one cycle keeps count unchanged. A full buffer with an R arriving is impossible by credit; the checker flags it as an error.
- Redirect (redirect_valid_i=1), with priority over everything except reset:
  - Buffer flushed; count=0 next cycle.
  - A handshake with the head in the same cycle still counts as consumed.
  - drop_cnt <= inflight after this cycle's R handshake and any launch. The outstanding un-handshaked AR is included.
  - fetch_pc and resp_pc <= redirect_pc_i; halted <= 0.
  - No launch in the redirect cycle. The first valid instruction from the new PC appears after all dropped responses.
- Back-to-back redirects: the later redirect wins. drop_cnt is recomputed from inflight.
- Reset mid-operation: all state returns to reset values next cycle. Bus responses owed to pre-reset requests are not tracked; the bus is reset together with the IFU.

Test Plan:
- Reset, slave with 1-cycle AR/R latency, D_ready_i=1 -> first AR addr 0x8000_0000, then 0x8000_0004, 0x8000_0008. The decode stream shows the matching pc_o with data, in order.
- D_ready_i=0, DEPTH=4 -> exactly 4 entries buffered, then mst_ar_valid_o stays 0. One D handshake -> one new AR at 0x8000_0010.
- Slave with 5-cycle R latency, MAX_OUT=2 -> inflight never exceeds 2; ARs at 0x8000_0000 and 0x8000_0004 launched before the first R.
- Two requests in flight, redirect_pc_i=0x8000_0100 -> both responses dropped (f_valid_o stays 0). The next AR addr is 0x8000_0100 and the next head pc_o is 0x8000_0100.
- R resp=2'b10 on the PC 0x8000_0008 fetch -> head with fault_o=1, pc_o=0x8000_0008. No further ARs until a redirect, after which fetch resumes at the redirect PC with fault_o=0.
- Redirect asserted in the same cycle as AR pending with ar_ready=0 -> AR address held until ready. Its response is dropped; fetch restarts at the redirect PC.
